// File: rtl/program_loader.sv
// Boot loader: parses a framed byte stream (SYNC, ADDR_HI, ADDR_LO, LEN, data[, CKSUM])
// into memory writes and holds the CPU in reset until the frame has loaded. Option: LOADER_CHECKSUM_EN.
module program_loader #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic        mem_write,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);
`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR_HI, S_ADDR_LO, S_LEN, S_DATA, S_CHECK, S_DONE, S_ERROR
    } state_e;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR_HI, S_ADDR_LO, S_LEN, S_DATA, S_DONE
    } state_e;
`endif

    state_e      state_q, state_d;
    logic [15:0] ptr_q, ptr_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_data_q, mem_data_d;
    logic        mem_write_q, mem_write_d;
    logic        done_q, done_d;
    logic        cpu_reset_q, cpu_reset_d;
    logic        armed_q;
    logic        fire;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  cksum_q, cksum_d;
    logic        error_q, error_d;
`endif

    // armed_q keeps in_ready low while reset is held and for the edge that releases it
`ifdef LOADER_CHECKSUM_EN
    assign in_ready = armed_q && (state_q != S_DONE) && (state_q != S_ERROR);
    assign error    = error_q;
`else
    assign in_ready = armed_q && (state_q != S_DONE);
    assign error    = 1'b0;
`endif
    assign fire      = in_valid && in_ready;
    assign mem_addr  = mem_addr_q;
    assign mem_data  = mem_data_q;
    assign mem_write = mem_write_q;
    assign done      = done_q;
    assign cpu_reset = cpu_reset_q;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        mem_write_d = 1'b0;
        done_d      = done_q;
`ifdef LOADER_CHECKSUM_EN
        cksum_d     = cksum_q;
        error_d     = error_q;
`endif
        case (state_q)
            S_IDLE: if (fire && in_data == SYNC_BYTE) begin
                state_d = S_ADDR_HI;
`ifdef LOADER_CHECKSUM_EN
                cksum_d = 8'h00;
`endif
            end
            S_ADDR_HI: if (fire) begin
                ptr_d[15:8] = in_data;
                state_d     = S_ADDR_LO;
            end
            S_ADDR_LO: if (fire) begin
                ptr_d[7:0] = in_data;
                state_d    = S_LEN;
            end
            S_LEN: if (fire) begin
                cnt_d   = (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
                state_d = S_DATA;
            end
            S_DATA: if (fire) begin
                mem_write_d = 1'b1;
                mem_addr_d  = ptr_q;
                mem_data_d  = in_data;
                ptr_d       = ptr_q + 16'd1;
                cnt_d       = cnt_q - 9'd1;
`ifdef LOADER_CHECKSUM_EN
                cksum_d     = cksum_q ^ in_data;
                if (cnt_q == 9'd1) state_d = S_CHECK;
`else
                if (cnt_q == 9'd1) state_d = S_DONE;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: if (fire) begin
                if (in_data == cksum_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_ERROR;
                    error_d = 1'b1;
                end
            end
`else
            // done lags entry to DONE by one edge so the last write lands before cpu_reset falls
            S_DONE: done_d = 1'b1;
`endif
            default: ;
        endcase
        cpu_reset_d = !done_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= 16'h0000;
            cnt_q       <= 9'd0;
            mem_addr_q  <= 16'h0000;
            mem_data_q  <= 8'h00;
            mem_write_q <= 1'b0;
            done_q      <= 1'b0;
            cpu_reset_q <= 1'b1;
            armed_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            cksum_q     <= 8'h00;
            error_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            mem_write_q <= mem_write_d;
            done_q      <= done_d;
            cpu_reset_q <= cpu_reset_d;
            armed_q     <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            cksum_q     <= cksum_d;
            error_q     <= error_d;
`endif
        end
    end
endmodule
